// File: rtl/div32_iter.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic [1:0]       i_divcontrol,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;

  logic             w_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_fin;

  assign w_signed = ~i_divcontrol[0];
  assign w_neg_a  = w_signed & i_srca[WIDTH-1];
  assign w_neg_b  = w_signed & i_srcb[WIDTH-1];
  // Negating the most negative value yields itself, which reads as 2^(WIDTH-1) unsigned.
  assign w_mag_a  = w_neg_a ? -i_srca : i_srca;
  assign w_mag_b  = w_neg_b ? -i_srcb : i_srcb;
  assign w_div0   = (i_srcb == '0);
  assign w_ovf    = w_signed & (i_srca == {1'b1, {(WIDTH-1){1'b0}}}) & (i_srcb == '1);

  // The partial remainder is always below the divisor, so only the shifted value needs the extra bit.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_rem_nx = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  assign w_q_fix  = (r_neg_a ^ r_neg_b) ? -w_quo_nx : w_quo_nx;
  assign w_r_fix  = r_neg_a ? -w_rem_nx : w_rem_nx;
  assign w_fin    = r_op[1] ? w_r_fix : w_q_fix;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_op    <= i_divcontrol;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            o_busy  <= 1'b1;
            if (w_div0) begin
              o_result <= i_divcontrol[1] ? i_srca : '1;
              o_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              o_result <= i_divcontrol[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
              o_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_quo   <= w_mag_a;
              r_dvs   <= w_mag_b;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH-1);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == '0) begin
            o_result <= w_fin;
            o_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
